// File: rtl/ir_queue.sv
// ir_queue: instruction register/queue between fetch and decode (LC-3b).
// Holds up to DEPTH fetched words, each tagged with its PC, and presents the
// head entry plus its decoded instruction fields to control/datapath.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      drop every entry (taken branch / JMP / TRAP)
//   enq_valid/enq_ready        fetch-side handshake, enq_instr + enq_pc payload
//   deq_valid/deq_ready        decode-side handshake for the head entry
//   instr, pc                  head word and its PC tag (0 when empty)
//   opcode..instruction11      raw field slices of the head word (0 when empty)
//   count                      occupancy 0..DEPTH
module ir_queue #(
  parameter int WIDTH = 16,
  parameter int PC_W  = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [WIDTH-1:0] enq_instr,
  input  logic [PC_W-1:0]  enq_pc,
  output logic             enq_ready,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] instr,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       opcode,
  output logic [2:0]       dest,
  output logic [2:0]       src1,
  output logic [2:0]       src2,
  output logic [10:0]      offset11,
  output logic [8:0]       offset9,
  output logic [7:0]       offset8,
  output logic [5:0]       offset6,
  output logic [4:0]       imm5,
  output logic [3:0]       imm4,
  output logic             instruction4,
  output logic             instruction5,
  output logic             instruction11,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PC_W+WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  enq_fire, deq_fire;

  // Handshake flags come only from the registered count, so a full queue
  // refuses a word even when decode drains one in the same cycle.
  assign enq_ready = (count != CNT_FULL);
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  // Storage needs no reset; an empty queue masks its contents below.
  always_ff @(posedge clk)
    if (enq_fire && !flush) mem[wr_ptr] <= {enq_pc, enq_instr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Explicit wrap keeps non-power-of-two depths correct.
      if (enq_fire) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is read straight out of storage; forced to zero when empty so
  // decode never sees stale words.
  assign {pc, instr} = deq_valid ? mem[rd_ptr] : '0;

  assign opcode        = instr[15:12];
  assign dest          = instr[11:9];
  assign src1          = instr[8:6];
  assign src2          = instr[2:0];
  assign offset11      = instr[10:0];
  assign offset9       = instr[8:0];
  assign offset8       = instr[7:0];
  assign offset6       = instr[5:0];
  assign imm5          = instr[4:0];
  assign imm4          = instr[3:0];
  assign instruction4  = instr[4];
  assign instruction5  = instr[5];
  assign instruction11 = instr[11];

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_FULL);
endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, enq_valid = 1'b0, deq_ready = 1'b0;
  logic [15:0] enq_instr = '0, enq_pc = '0;

  // index 0: DEPTH=4 instance, index 1: DEPTH=3 instance (non power of two)
  logic        enq_ready [2], deq_valid [2];
  logic [15:0] instr [2], pc [2];
  logic [3:0]  opcode [2], imm4 [2];
  logic [2:0]  dest [2], src1 [2], src2 [2];
  logic [10:0] offset11 [2];
  logic [8:0]  offset9 [2];
  logic [7:0]  offset8 [2];
  logic [5:0]  offset6 [2];
  logic [4:0]  imm5 [2];
  logic        i4 [2], i5 [2], i11 [2];
  logic [2:0]  count4;
  logic [1:0]  count3;

  int vectors = 0, miscompares = 0;
  logic [31:0] q0[$], q1[$];  // reference FIFOs of {pc,instr}
  bit e0, d0, e1, d1;

  always #5 clk = ~clk;

  ir_queue #(.DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .enq_valid(enq_valid), .enq_instr(enq_instr),
    .enq_pc(enq_pc), .enq_ready(enq_ready[0]), .deq_valid(deq_valid[0]), .deq_ready(deq_ready),
    .instr(instr[0]), .pc(pc[0]), .opcode(opcode[0]), .dest(dest[0]), .src1(src1[0]),
    .src2(src2[0]), .offset11(offset11[0]), .offset9(offset9[0]), .offset8(offset8[0]),
    .offset6(offset6[0]), .imm5(imm5[0]), .imm4(imm4[0]), .instruction4(i4[0]),
    .instruction5(i5[0]), .instruction11(i11[0]), .count(count4));

  ir_queue #(.DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .enq_valid(enq_valid), .enq_instr(enq_instr),
    .enq_pc(enq_pc), .enq_ready(enq_ready[1]), .deq_valid(deq_valid[1]), .deq_ready(deq_ready),
    .instr(instr[1]), .pc(pc[1]), .opcode(opcode[1]), .dest(dest[1]), .src1(src1[1]),
    .src2(src2[1]), .offset11(offset11[1]), .offset9(offset9[1]), .offset8(offset8[1]),
    .offset6(offset6[1]), .imm5(imm5[1]), .imm4(imm4[1]), .instruction4(i4[1]),
    .instruction5(i5[1]), .instruction11(i11[1]), .count(count3));

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Field slices of a 16-bit LC-3b word, as named in the port list.
  function automatic logic [63:0] fexp(logic [15:0] w);
    return {5'b0, w[15:12], w[11:9], w[8:6], w[2:0], w[10:0], w[8:0], w[7:0], w[5:0],
            w[4:0], w[3:0], w[4], w[5], w[11]};
  endfunction

  function automatic logic [63:0] fobs(int i);
    return {5'b0, opcode[i], dest[i], src1[i], src2[i], offset11[i], offset9[i], offset8[i],
            offset6[i], imm5[i], imm4[i], i4[i], i5[i], i11[i]};
  endfunction

  task automatic check(string tag);
    logic [31:0] h;
    int n;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? q0.size() : q1.size();
      h = (n == 0) ? 32'h0 : ((i == 0) ? q0[0] : q1[0]);
      chk($sformatf("%s/d%0d/count", tag, 4-i), (i == 0) ? 64'(count4) : 64'(count3), 64'(n));
      chk($sformatf("%s/d%0d/deq_valid", tag, 4-i), 64'(deq_valid[i]), 64'(n != 0));
      chk($sformatf("%s/d%0d/enq_ready", tag, 4-i), 64'(enq_ready[i]), 64'(n < 4-i));
      chk($sformatf("%s/d%0d/head", tag, 4-i), {32'h0, pc[i], instr[i]}, {32'h0, h});
      chk($sformatf("%s/d%0d/fields", tag, 4-i), fobs(i), fexp(h[15:0]));
    end
  endtask

  // One clock: check mid-cycle, then advance model and DUT together.
  task automatic cycle(string tag);
    #3;
    check(tag);
    d0 = deq_ready && q0.size() > 0;  e0 = enq_valid && q0.size() < 4;
    d1 = deq_ready && q1.size() > 0;  e1 = enq_valid && q1.size() < 3;
    @(posedge clk);
    if (!rst_n || flush) begin
      q0.delete(); q1.delete();
    end else begin
      if (d0) void'(q0.pop_front());
      if (e0) q0.push_back({enq_pc, enq_instr});
      if (d1) void'(q1.pop_front());
      if (e1) q1.push_back({enq_pc, enq_instr});
    end
    #1;
  endtask

  initial begin
    // 1. reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("in_reset");
    rst_n = 1'b1;
    cycle("idle");
    chk("t1_opcode", 64'(opcode[0]), 64'h0);
    chk("t1_instr", 64'(instr[0]), 64'h0);
    chk("t1_enq_ready", 64'(enq_ready[0]), 64'h1);

    // 2. single ADD, head visible after the edge
    enq_valid = 1'b1; enq_instr = 16'h1283; enq_pc = 16'h0040;
    cycle("t2_enq");
    enq_valid = 1'b0;
    chk("t2_deq_valid", 64'(deq_valid[0]), 64'h1);
    chk("t2_opcode", 64'(opcode[0]), 64'h1);
    chk("t2_dest", 64'(dest[0]), 64'h1);
    chk("t2_src1", 64'(src1[0]), 64'h2);
    chk("t2_src2", 64'(src2[0]), 64'h3);
    chk("t2_i5", 64'(i5[0]), 64'h0);
    chk("t2_pc", 64'(pc[0]), 64'h0040);
    cycle("t2_hold");

    // 3. fill with 5 back-to-back words; 5th held
    flush = 1'b1;
    cycle("t3_flush");
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      enq_valid = 1'b1; enq_instr = 16'h1000 + 16'(k * 16'h0111); enq_pc = 16'h0100 + 16'(2 * k);
      cycle($sformatf("t3_enq%0d", k));
    end
    chk("t3_count", 64'(count4), 64'h4);
    chk("t3_enq_ready", 64'(enq_ready[0]), 64'h0);

    // 4. full with both handshakes: dequeue only, then both fire across wrap
    deq_ready = 1'b1;
    cycle("t4_full_both");
    chk("t4_count_a", 64'(count4), 64'h3);
    cycle("t4_both");
    chk("t4_count_b", 64'(count4), 64'h3);
    enq_valid = 1'b0;
    for (int k = 0; k < 5; k++) cycle($sformatf("t4_drain%0d", k));
    deq_ready = 1'b0;

    // 5. flush wins over an enqueue of JMP
    for (int k = 0; k < 2; k++) begin
      enq_valid = 1'b1; enq_instr = 16'h2000 + 16'(k); enq_pc = 16'h0200 + 16'(2 * k);
      cycle($sformatf("t5_enq%0d", k));
    end
    chk("t5_count2", 64'(count4), 64'h2);
    flush = 1'b1; enq_instr = 16'hC1C0; enq_pc = 16'h0204;
    cycle("t5_flush");
    flush = 1'b0; enq_valid = 1'b0;
    chk("t5_count0", 64'(count4), 64'h0);
    chk("t5_deq_valid", 64'(deq_valid[0]), 64'h0);
    cycle("t5_after");

    // 6. async reset mid-cycle at count=3
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1'b1; enq_instr = 16'h3000 + 16'(k); enq_pc = 16'h0300 + 16'(2 * k);
      cycle($sformatf("t6_enq%0d", k));
    end
    enq_valid = 1'b0;
    #2;
    rst_n = 1'b0; q0.delete(); q1.delete();
    #1;
    check("t6_async");
    cycle("t6_in_reset");
    rst_n = 1'b1;
    enq_valid = 1'b1; enq_instr = 16'h5020; enq_pc = 16'h0400;
    cycle("t6_enq");
    enq_valid = 1'b0;
    chk("t6_imm5", 64'(imm5[0]), 64'h0);
    chk("t6_i5", 64'(i5[0]), 64'h1);
    chk("t6_opcode", 64'(opcode[0]), 64'h5);
    cycle("t6_hold");

    // randomized traffic against the reference FIFOs
    for (int k = 0; k < 600; k++) begin
      enq_valid = 1'($urandom_range(0, 1));
      deq_ready = 1'($urandom_range(0, 1));
      enq_instr = 16'($urandom);
      enq_pc    = 16'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 79) != 0);
      if (!rst_n) begin q0.delete(); q1.delete(); end
      cycle("rand");
      rst_n = 1'b1;
    end
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    cycle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
